sr_ff_monitor: RTL and testbench
================================

// Module: sr_ff_monitor
// PURPOSE
//  Synthesizable checker for a clocked SR flip-flop. It consumes the flip-flop's S/R inputs and its Q/Qbar outputs.
//  It predicts Q from S/R and flags any mismatch, illegal S=R=1 command or broken complement.
//  It sits beside the flip-flop in FPGA builds and benches, and exposes error counters and a sticky fail flag for LEDs.
// PARAMETERS
//  CNT_W   8   width of err_count and illegal_count (both saturate at 2^CNT_W-1)
// PORTS
//  clk            in   1      rising-edge clock, shared with the monitored flip-flop
//  rst_n          in   1      asynchronous active-low reset
//  en             in   1      arm monitor; 0 = DISARMED
//  clear          in   1      synchronous clear of counters and sticky_fail
//  S              in   1      set input driven into the flip-flop
//  R              in   1      reset input driven into the flip-flop
//  Q              in   1      flip-flop output
//  Qbar           in   1      flip-flop complement output
//  exp_q          out  1      predicted Q; meaningful only when exp_valid=1
//  exp_valid      out  1      1 while state = TRACKING
//  mismatch       out  1      1-cycle pulse: Q != exp_q
//  illegal        out  1      1-cycle pulse: S=R=1 sampled while armed
//  comp_err       out  1      1-cycle pulse: Qbar != ~Q
//  err_count      out  CNT_W  count of mismatch + comp_err events
//  illegal_count  out  CNT_W  count of illegal events
//  sticky_fail    out  1      set by any mismatch/comp_err/illegal; held until clear or reset
//  state          out  2      00 DISARMED, 01 UNKNOWN, 10 TRACKING
// BEHAVIOUR
//  - Reset: all outputs and internal registers = 0; state = DISARMED.
//  - All sampling happens on posedge clk.
//  - Prediction, applied to S,R at edge k:
//      10 -> exp_q = 1
//      01 -> exp_q = 0
//      00 -> hold
//      11 -> exp_q undefined
//  - State transitions:
//      any state, en=0 -> DISARMED
//      DISARMED, en=1 -> UNKNOWN (no checks on that edge)
//      UNKNOWN, S/R = 10 or 01 -> TRACKING, with exp_q loaded
//      UNKNOWN, S/R = 00 -> stay
//      any armed state, S/R = 11 -> UNKNOWN, illegal pulse
//  - Check latency: the Q/Qbar sampled at edge k+1 is compared against the exp_q formed at edge k.
//  - mismatch asserts on edge k+1 only if state was TRACKING after edge k.
//  - comp_err is checked every armed edge. It is suppressed on the edge right after an illegal, since Q=Qbar is
//    legal there, and on the first edge after arming.
//  - mismatch and comp_err firing on the same edge add 2 to err_count (saturating).
//  - Counters saturate and never wrap.
//  - clear wins over simultaneous events on that edge: counters = 0, sticky_fail = 0, pulses still shown.
//  - clear does not change state or exp_q.
//  - Event pulses are registered outputs, high for exactly one cycle per event.
//  - rst_n low mid-operation: immediate return to reset values, independent of clk.
//  - Deasserting en mid-TRACKING discards exp_q (exp_valid = 0). Re-arming starts in UNKNOWN.
// TESTING
//  1. Reset, en=1; S/R=10, then correct Q=1/Qbar=0 -> TRACKING, exp_q=1, no pulses, err_count=0.
//  2. In TRACKING with exp_q=1, force Q=0/Qbar=1 for one edge -> mismatch pulse 1 cycle, err_count=1, sticky_fail=1.
//  3. S/R=11 -> illegal pulse, illegal_count=1, state=UNKNOWN; next edge Q=Qbar=0 -> no comp_err;
//     S/R=00 -> stays UNKNOWN, no mismatch.
//  4. Drive 300 consecutive mismatches with CNT_W=8 -> err_count saturates at 255; then clear=1 -> 0,
//     sticky_fail=0, state unchanged.
//  5. clear=1 on the same edge as a mismatch -> mismatch pulse seen, err_count=0, sticky_fail=0.
//  6. Drop rst_n between clock edges during TRACKING -> all outputs 0 and state=DISARMED immediately.
//     Release rst_n, en=0 -> remains DISARMED with no checks.

Source files
------------

// File: rtl/sr_ff_monitor.sv
// Checker for a clocked SR flip-flop. It predicts Q from S/R, flags Q mismatches,
// illegal S=R=1 commands and broken Q/Qbar complements, and keeps saturating
// error counters plus a sticky fail flag.
module sr_ff_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             S,
    input  logic             R,
    input  logic             Q,
    input  logic             Qbar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             illegal,
    output logic             comp_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic             sticky_fail,
    output logic [1:0]       state
);

    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [1:0] ST_DIS = 2'b00;
    localparam logic [1:0] ST_UNK = 2'b01;
    localparam logic [1:0] ST_TRK = 2'b10;
    localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [1:0]       state_nx;
    logic             armed_c;
    logic             mismatch_c;
    logic             comp_err_c;
    logic             illegal_c;
    logic             exp_q_nx;
    logic             first_nx;
    logic [SUM_W-1:0] err_sum_c;
    logic [SUM_W-1:0] ill_sum_c;
    logic [CNT_W-1:0] err_count_nx;
    logic [CNT_W-1:0] illegal_count_nx;
    logic             sticky_nx;

    // First armed edge after arming, and edge right after an illegal: no complement check.
    logic             first_q;
    logic             after_ill_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DIS;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: en=0 always disarms; an illegal command drops back to UNKNOWN.
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = ST_DIS;
        end else begin
            case (state)
                ST_DIS: state_nx = ST_UNK;
                ST_UNK, ST_TRK: begin
                    if (S && R) begin
                        state_nx = ST_UNK;
                    end else if (S ^ R) begin
                        state_nx = ST_TRK;
                    end
                end
                default: state_nx = ST_DIS;
            endcase
        end
    end

    // Event detection, prediction update and saturating counter arithmetic.
    always_comb begin
        armed_c    = en && ((state == ST_UNK) || (state == ST_TRK));
        mismatch_c = armed_c && (state == ST_TRK) && (Q != exp_q);
        comp_err_c = armed_c && (Q == Qbar) && !first_q && !after_ill_q;
        illegal_c  = armed_c && S && R;

        exp_q_nx = exp_q;
        if (!en) begin
            exp_q_nx = 1'b0;
        end else if (armed_c && (S ^ R)) begin
            exp_q_nx = S;
        end

        first_nx = en && (state == ST_DIS);

        err_sum_c = SUM_W'(err_count) + SUM_W'(mismatch_c) + SUM_W'(comp_err_c);
        ill_sum_c = SUM_W'(illegal_count) + SUM_W'(illegal_c);

        err_count_nx     = (err_sum_c > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum_c[CNT_W-1:0];
        illegal_count_nx = (ill_sum_c > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : ill_sum_c[CNT_W-1:0];
        sticky_nx        = sticky_fail || mismatch_c || comp_err_c || illegal_c;

        if (clear) begin
            err_count_nx     = '0;
            illegal_count_nx = '0;
            sticky_nx        = 1'b0;
        end
    end

    // Registered outputs and suppression flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q         <= 1'b0;
            exp_valid     <= 1'b0;
            mismatch      <= 1'b0;
            illegal       <= 1'b0;
            comp_err      <= 1'b0;
            err_count     <= '0;
            illegal_count <= '0;
            sticky_fail   <= 1'b0;
            first_q       <= 1'b0;
            after_ill_q   <= 1'b0;
        end else begin
            exp_q         <= exp_q_nx;
            exp_valid     <= (state_nx == ST_TRK);
            mismatch      <= mismatch_c;
            illegal       <= illegal_c;
            comp_err      <= comp_err_c;
            err_count     <= err_count_nx;
            illegal_count <= illegal_count_nx;
            sticky_fail   <= sticky_nx;
            first_q       <= first_nx;
            after_ill_q   <= illegal_c;
        end
    end

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Self-checking bench for sr_ff_monitor: directed scenarios followed by random
// traffic, all checked against a behavioural model of the checker's rules.
module tb_sr_ff_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    logic en, clear, S, R, Q, Qbar;
    logic exp_q, exp_valid, mismatch, illegal, comp_err, sticky_fail;
    logic [CNT_W-1:0] err_count, illegal_count;
    logic [1:0] state;

    sr_ff_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .S(S), .R(R), .Q(Q), .Qbar(Qbar),
        .exp_q(exp_q), .exp_valid(exp_valid), .mismatch(mismatch),
        .illegal(illegal), .comp_err(comp_err), .err_count(err_count),
        .illegal_count(illegal_count), .sticky_fail(sticky_fail), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Model: monitor status (0 disarmed, 1 unknown, 2 tracking), prediction, history, tallies.
    int m_state, m_pred, m_err, m_ill, m_sticky;
    bit m_just_armed, m_after_ill;
    bit m_mis, m_ce, m_il;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pred = 0; m_err = 0; m_ill = 0; m_sticky = 0;
        m_just_armed = 0; m_after_ill = 0; m_mis = 0; m_ce = 0; m_il = 0;
    endtask

    task automatic model_edge(input bit e, input bit c, input bit s, input bit r, input bit q, input bit qb);
        m_mis = 0; m_ce = 0; m_il = 0;
        if (!e) begin
            m_state = 0; m_just_armed = 0; m_after_ill = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_just_armed = 1; m_after_ill = 0;
        end else begin
            m_mis = (m_state == 2) && (int'(q) != m_pred);
            m_ce  = (q == qb) && !m_just_armed && !m_after_ill;
            m_il  = s && r;
            m_just_armed = 0;
            m_after_ill  = m_il;
            if (m_il) m_state = 1;
            else if (s != r) begin m_state = 2; m_pred = int'(s); end
        end
        if (c) begin
            m_err = 0; m_ill = 0; m_sticky = 0;
        end else begin
            m_err = m_err + int'(m_mis) + int'(m_ce);
            if (m_err > CMAX) m_err = CMAX;
            m_ill = m_ill + int'(m_il);
            if (m_ill > CMAX) m_ill = CMAX;
            if (m_mis || m_ce || m_il) m_sticky = 1;
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("exp_valid", 32'(exp_valid), 32'(m_state == 2));
        if (m_state == 2) chk("exp_q", 32'(exp_q), 32'(m_pred));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        chk("illegal", 32'(illegal), 32'(m_il));
        chk("comp_err", 32'(comp_err), 32'(m_ce));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("illegal_count", 32'(illegal_count), 32'(m_ill));
        chk("sticky_fail", 32'(sticky_fail), 32'(m_sticky));
    endtask

    task automatic step(input bit e, input bit c, input bit s, input bit r, input bit q, input bit qb);
        en = e; clear = c; S = s; R = r; Q = q; Qbar = qb;
        @(posedge clk);
        model_edge(e, c, s, r, q, qb);
        #1;
        check_all();
    endtask

    initial begin
        bit e, c, s, r, q, qb;
        rst_n = 1'b0;
        en = 0; clear = 0; S = 0; R = 0; Q = 0; Qbar = 1;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Arm, set, then correct Q -> tracking, clean.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0);
        chk("t1_state_trk", 32'(state), 32'd2);
        chk("t1_expq", 32'(exp_q), 32'd1);

        // Single forced mismatch, then correct again.
        step(1, 0, 0, 0, 0, 1);
        chk("t2_mis", 32'(mismatch), 32'd1);
        chk("t2_err", 32'(err_count), 32'd1);
        step(1, 0, 0, 0, 1, 0);
        chk("t2_mis_pulse_end", 32'(mismatch), 32'd0);

        // Illegal command, Q=Qbar allowed on next edge, 00 keeps UNKNOWN.
        step(1, 0, 1, 1, 1, 0);
        chk("t3_ill_cnt", 32'(illegal_count), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("t3_no_ce", 32'(comp_err), 32'd0);
        step(1, 0, 0, 0, 1, 0);
        chk("t3_unk", 32'(state), 32'd1);

        // 300 mismatches saturate err_count, then clear.
        step(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, 1);
        chk("t4_sat", 32'(err_count), 32'(CMAX));
        step(1, 1, 0, 0, 1, 0);
        chk("t4_clr_err", 32'(err_count), 32'd0);
        chk("t4_clr_state", 32'(state), 32'd2);

        // Clear on the same edge as a mismatch.
        step(1, 1, 0, 0, 0, 1);
        chk("t5_mis", 32'(mismatch), 32'd1);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_sticky", 32'(sticky_fail), 32'd0);

        // Asynchronous reset between edges during tracking.
        step(1, 0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("t6_dis", 32'(state), 32'd0);

        // Random traffic; Q usually follows the prediction, Qbar usually complements.
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 15) != 0);
            c  = ($urandom_range(0, 31) == 0);
            s  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            q  = ($urandom_range(0, 3) != 0) ? 1'(m_pred) : 1'($urandom_range(0, 1));
            qb = ($urandom_range(0, 7) != 0) ? ~q : q;
            step(e, c, s, r, q, qb);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
